be_sdp_ram_ctrl: RTL and testbench

//  Parametrised byte-enabled simple dual-port RAM: one write port, one read port, one clock.

---
 rtl/be_sdp_ram_pkg.sv | 29 ++
 rtl/be_sdp_ram_clear_seq.sv | 62 ++++++
 rtl/be_sdp_ram_ctrl.sv | 118 +++++++++++
 tb/tb_be_sdp_ram_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/be_sdp_ram_pkg.sv
// rtl/be_sdp_ram_pkg.sv - shared types and per-lane merge helper for the byte-enabled SDP RAM
package be_sdp_ram_pkg;

    typedef enum logic {ST_CLEAR, ST_RUN} ram_state_t;

    // Widest word/lane count lane_merge accepts; callers zero-extend into these and truncate back.
    localparam int LM_MAX_BITS  = 1024;
    localparam int LM_MAX_LANES = 128;

    // Lane i of the result takes new_word when be[i] is set, otherwise keeps old_word.
    function automatic logic [LM_MAX_BITS-1:0] lane_merge(
        input logic [LM_MAX_BITS-1:0]  old_word,
        input logic [LM_MAX_BITS-1:0]  new_word,
        input logic [LM_MAX_LANES-1:0] be,
        input int                      byte_width
    );
        logic [LM_MAX_BITS-1:0] res;
        logic [6:0]             lane;
        res = old_word;
        for (int j = 0; j < LM_MAX_BITS; j++) begin
            lane = 7'(j / byte_width);
            if (be[lane]) begin
                res[10'(j)] = new_word[10'(j)];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/be_sdp_ram_clear_seq.sv
// rtl/be_sdp_ram_clear_seq.sv - reset-driven clear sequencer and memory write-port mux
module be_sdp_ram_clear_seq
    import be_sdp_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_BYTES  = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [NUM_BYTES-1:0]  be,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [NUM_BYTES-1:0]  mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);

    ram_state_t            state;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  waddr_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
            busy     <= 1'b1;
        end else if (state == ST_CLEAR) begin
            if (clr_addr == LAST_ADDR) begin
                state <= ST_RUN;
                busy  <= 1'b0;
            end else begin
                clr_addr <= clr_addr + ADDR_WIDTH'(1);
            end
        end
    end

    assign waddr_ok = ({1'b0, waddr} < DEPTH_W);

    // While clearing, the sequencer owns the write port and user writes are discarded.
    always_comb begin
        if (state == ST_CLEAR) begin
            mem_we    = !rst;
            mem_addr  = clr_addr;
            mem_be    = '1;
            mem_wdata = '0;
        end else begin
            mem_we    = !rst && we && waddr_ok;
            mem_addr  = waddr;
            mem_be    = be;
            mem_wdata = wdata;
        end
    end

endmodule

// File: rtl/be_sdp_ram_ctrl.sv
// rtl/be_sdp_ram_ctrl.sv - byte-enabled simple dual-port RAM with clear, rvalid and write-first forwarding
// Optional BE_SDP_RAM_OUT_REG_EN adds a second output register (read latency 2).
module be_sdp_ram_ctrl
    import be_sdp_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             we,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be,
    input  logic [ADDR_WIDTH-1:0]            waddr,
    input  logic [DATA_WIDTH-1:0]            wdata,
    input  logic                             re,
    input  logic [ADDR_WIDTH-1:0]            raddr,
    output logic [DATA_WIDTH-1:0]            q,
    output logic                             rvalid,
    output logic                             busy
);

    localparam int                  NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [NUM_BYTES-1:0]  mem_be;
    logic [DATA_WIDTH-1:0] mem_wdata;

    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] fwd_word;
    logic                  raddr_ok;
    logic                  fwd_hit;

    logic [DATA_WIDTH-1:0] q_s1;
    logic                  rvalid_s1;

    be_sdp_ram_clear_seq #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_BYTES  (NUM_BYTES),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_clear_seq (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .be        (be),
        .waddr     (waddr),
        .wdata     (wdata),
        .busy      (busy),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata)
    );

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= DATA_WIDTH'(lane_merge(LM_MAX_BITS'(mem[mem_addr]),
                                                    LM_MAX_BITS'(mem_wdata),
                                                    LM_MAX_LANES'(mem_be),
                                                    BYTE_WIDTH));
        end
    end

    // Same-address write in the read cycle is forwarded lane by lane (write-first).
    assign raddr_ok = ({1'b0, raddr} < DEPTH_W);
    assign fwd_hit  = we && (waddr == raddr);
    assign rd_word  = mem[raddr];

    always_comb begin
        fwd_word = rd_word;
        if (fwd_hit) begin
            fwd_word = DATA_WIDTH'(lane_merge(LM_MAX_BITS'(rd_word),
                                              LM_MAX_BITS'(wdata),
                                              LM_MAX_LANES'(be),
                                              BYTE_WIDTH));
        end
    end

    always_ff @(posedge clk) begin
        if (rst || busy) begin
            q_s1      <= '0;
            rvalid_s1 <= 1'b0;
        end else begin
            rvalid_s1 <= re;
            if (re) begin
                q_s1 <= raddr_ok ? fwd_word : '0;
            end
        end
    end

`ifdef BE_SDP_RAM_OUT_REG_EN
    logic [DATA_WIDTH-1:0] q_s2;
    logic                  rvalid_s2;

    always_ff @(posedge clk) begin
        if (rst || busy) begin
            q_s2      <= '0;
            rvalid_s2 <= 1'b0;
        end else begin
            q_s2      <= q_s1;
            rvalid_s2 <= rvalid_s1;
        end
    end

    assign q      = q_s2;
    assign rvalid = rvalid_s2;
`else
    assign q      = q_s1;
    assign rvalid = rvalid_s1;
`endif

endmodule

// File: tb/tb_be_sdp_ram_ctrl.sv
// tb/tb_be_sdp_ram_ctrl.sv - self-checking bench for be_sdp_ram_ctrl (DEPTH 256 and 200 instances)
module tb_be_sdp_ram_ctrl;

`ifdef BE_SDP_RAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int D0 = 256;
    localparam int D1 = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [3:0]  be = 4'h0;
    logic [7:0]  waddr = 8'h0;
    logic [7:0]  raddr = 8'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] q0, q1;
    logic        rv0, rv1, busy0, busy1;

    always #5 clk = ~clk;

    be_sdp_ram_ctrl #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(D0)) dut0 (
        .clk(clk), .rst(rst), .we(we), .be(be), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .q(q0), .rvalid(rv0), .busy(busy0)
    );

    be_sdp_ram_ctrl #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(D1)) dut1 (
        .clk(clk), .rst(rst), .we(we), .be(be), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .q(q1), .rvalid(rv1), .busy(busy1)
    );

    int tests = 0;
    int fails = 0;

    // Reference: word array per instance, remaining clear cycles, and a read-result pipeline.
    logic [31:0] mm [2][256];
    int          clr_left [2] = '{0, 0};
    logic [31:0] pq [2][2];
    logic        prv [2][2];

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [7:0]  waddr;
        logic [31:0] wdata;
        logic        re;
        logic [7:0]  raddr;
        logic [31:0] exp_q;
    } vec_t;

    vec_t vt [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        int          dep;
        logic [31:0] res;
        for (int d = 0; d < 2; d++) begin
            dep = (d == 0) ? D0 : D1;
            if (rst || clr_left[d] > 0) begin
                for (int s = 0; s < 2; s++) begin
                    pq[d][s]  = 32'h0;
                    prv[d][s] = 1'b0;
                end
                if (rst) begin
                    clr_left[d] = dep;
                    for (int a = 0; a < 256; a++) mm[d][a] = 32'h0;
                end else begin
                    clr_left[d]--;
                end
            end else begin
                res = 32'h0;
                if (int'(raddr) < dep) begin
                    for (int i = 0; i < 4; i++) begin
                        if (we && be[i] && waddr == raddr)
                            res[8*i +: 8] = wdata[8*i +: 8];
                        else
                            res[8*i +: 8] = mm[d][raddr][8*i +: 8];
                    end
                end
                if (we && int'(waddr) < dep) begin
                    for (int i = 0; i < 4; i++)
                        if (be[i]) mm[d][waddr][8*i +: 8] = wdata[8*i +: 8];
                end
                pq[d][1]  = pq[d][0];
                prv[d][1] = prv[d][0];
                prv[d][0] = re;
                if (re) pq[d][0] = res;
            end
        end
        @(posedge clk);
        #1;
        chk("busy0", 32'(busy0), 32'(clr_left[0] > 0));
        chk("busy1", 32'(busy1), 32'(clr_left[1] > 0));
        chk("rvalid0", 32'(rv0), 32'(prv[0][LAT-1]));
        chk("rvalid1", 32'(rv1), 32'(prv[1][LAT-1]));
        chk("q0", q0, pq[0][LAT-1]);
        chk("q1", q1, pq[1][LAT-1]);
    endtask

    task automatic idle_inputs();
        we = 1'b0;
        re = 1'b0;
        be = 4'h0;
    endtask

    function automatic logic [7:0] rand_addr();
        case ($urandom_range(0, 3))
            0, 1:    return 8'($urandom_range(0, 7));
            2:       return 8'($urandom_range(196, 203));
            default: return 8'($urandom_range(248, 255));
        endcase
    endfunction

    task automatic rand_inputs();
        we    = ($urandom_range(0, 1) == 1);
        re    = ($urandom_range(0, 9) < 7);
        be    = 4'($urandom);
        wdata = $urandom;
        waddr = rand_addr();
        raddr = ($urandom_range(0, 2) == 0) ? waddr : rand_addr();
    endtask

    // Counts busy cycles from rst release; abort_at >= 0 stops early after that many cycles.
    task automatic run_busy(input int abort_at, output int c0, output int c1);
        c0 = busy0 ? 1 : 0;
        c1 = busy1 ? 1 : 0;
        for (int n = 0; n < 400; n++) begin
            if (n == abort_at) break;
            rand_inputs();
            tick();
            c0 += busy0 ? 1 : 0;
            c1 += busy1 ? 1 : 0;
            if (!busy0 && !busy1) break;
        end
        idle_inputs();
    endtask

    task automatic read_all();
        for (int a = 0; a < 256; a++) begin
            we    = 1'b0;
            re    = 1'b1;
            raddr = 8'(a);
            tick();
        end
        idle_inputs();
        tick();
        tick();
    endtask

    initial begin
        int c0, c1;

        vt[0] = '{1'b1, 4'b1111, 8'd5, 32'hDEADBEEF, 1'b0, 8'd0, 32'h0};
        vt[1] = '{1'b0, 4'b0000, 8'd0, 32'h0,        1'b1, 8'd5, 32'hDEADBEEF};
        vt[2] = '{1'b1, 4'b0101, 8'd5, 32'h11223344, 1'b0, 8'd0, 32'h0};
        vt[3] = '{1'b0, 4'b0000, 8'd0, 32'h0,        1'b1, 8'd5, 32'hDE22BE44};
        vt[4] = '{1'b1, 4'b0000, 8'd5, 32'hFFFFFFFF, 1'b0, 8'd0, 32'h0};
        vt[5] = '{1'b0, 4'b0000, 8'd0, 32'h0,        1'b1, 8'd5, 32'hDE22BE44};
        vt[6] = '{1'b1, 4'b1111, 8'd7, 32'hAAAAAAAA, 1'b0, 8'd0, 32'h0};
        vt[7] = '{1'b1, 4'b0011, 8'd7, 32'h12345678, 1'b1, 8'd7, 32'hAAAA5678};
        vt[8] = '{1'b0, 4'b0000, 8'd0, 32'h0,        1'b1, 8'd7, 32'hAAAA5678};

        // Reset and clear length, then the whole array reads back as zero.
        rst = 1'b1;
        tick();
        tick();
        chk("reset_q0", q0, 32'h0);
        chk("reset_rvalid0", 32'(rv0), 32'h0);
        rst = 1'b0;
        run_busy(-1, c0, c1);
        chk("busy_len0", 32'(c0), 32'(D0));
        chk("busy_len1", 32'(c1), 32'(D1));
        read_all();

        // Directed writes, masked writes and same-cycle collision.
        for (int k = 0; k < 9; k++) begin
            we    = vt[k].we;
            be    = vt[k].be;
            waddr = vt[k].waddr;
            wdata = vt[k].wdata;
            re    = vt[k].re;
            raddr = vt[k].raddr;
            tick();
            idle_inputs();
            for (int l = 1; l < LAT; l++) tick();
            if (vt[k].re) begin
                chk($sformatf("vec%0d_q", k), q0, vt[k].exp_q);
                chk($sformatf("vec%0d_rvalid", k), 32'(rv0), 32'h1);
            end
            tick();
            if (vt[k].re) chk($sformatf("vec%0d_rvalid_drop", k), 32'(rv0), 32'h0);
        end

        // Depth boundary on the 200-word instance.
        we = 1'b1; be = 4'hF; waddr = 8'd199; wdata = 32'h0BADF00D;
        tick();
        we = 1'b0; re = 1'b1; raddr = 8'd199;
        tick();
        idle_inputs();
        for (int l = 1; l < LAT; l++) tick();
        chk("d1_last_word", q1, 32'h0BADF00D);
        we = 1'b1; be = 4'hF; waddr = 8'd221; wdata = 32'hCAFEF00D;
        tick();
        we = 1'b0; re = 1'b1; raddr = 8'd221;
        tick();
        idle_inputs();
        for (int l = 1; l < LAT; l++) tick();
        chk("d1_oor_q", q1, 32'h0);
        chk("d1_oor_rvalid", 32'(rv1), 32'h1);
        chk("d0_221_q", q0, 32'hCAFEF00D);
        tick();

        // Randomized traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            rand_inputs();
            tick();
        end
        idle_inputs();
        tick();
        tick();

        // Reset in the middle of a clear restarts it; prior contents are gone.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run_busy(100, c0, c1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run_busy(-1, c0, c1);
        chk("rebusy_len0", 32'(c0), 32'(D0));
        chk("rebusy_len1", 32'(c1), 32'(D1));
        read_all();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
